// File: rtl/register_file_dump_ctrl_pkg.sv
// Shared constants, FSM state type and helper for the register-file dump sequencer
// and the other debug/UART blocks.
package register_file_dump_ctrl_pkg;

  localparam int unsigned DEF_NB_BYTE        = 8;
  localparam int unsigned DEF_NB_DATA        = 32;
  localparam int unsigned DEF_BYTES_PER_WORD = DEF_NB_DATA / DEF_NB_BYTE;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StSend = 3'd2,
    StCsum = 3'd3,
    StDone = 3'd4
  } state_e;

  // Counter width that stays legal when only one value is needed.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/register_file_dump_ctrl_if.sv
// Bundle of the debug-unit handshake, register-file debug port and TX byte stream.
// Signal prefixes are from the dump controller's point of view.
interface register_file_dump_ctrl_if
  import register_file_dump_ctrl_pkg::*;
#(
  parameter int unsigned NB_DATA = DEF_NB_DATA,
  parameter int unsigned N_REGS  = 32,
  parameter int unsigned NB_BYTE = DEF_NB_BYTE,
  parameter int unsigned NB_ADDR = $clog2(N_REGS)
);

  logic               i_start;
  logic               o_busy;
  logic               o_done;
  logic [NB_ADDR-1:0] o_read_addr_debug;
  logic [NB_DATA-1:0] i_data_debug;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;

  modport slave (
    input  i_start,
    input  i_data_debug,
    input  i_tx_ready,
    output o_busy,
    output o_done,
    output o_read_addr_debug,
    output o_tx_data,
    output o_tx_valid
  );

  modport master (
    output i_start,
    output i_data_debug,
    output i_tx_ready,
    input  o_busy,
    input  o_done,
    input  o_read_addr_debug,
    input  o_tx_data,
    input  o_tx_valid
  );

endinterface

// File: rtl/register_file_dump_ctrl_word_to_byte_serializer.sv
// Captures one register word and emits it little-endian, one byte per valid/ready handshake;
// flags the acceptance of the last byte back to the dump FSM.
module word_to_byte_serializer
  import register_file_dump_ctrl_pkg::*;
#(
  parameter int unsigned NB_DATA = DEF_NB_DATA,
  parameter int unsigned NB_BYTE = DEF_NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_en,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_last_acc
);

  localparam int unsigned BPW      = NB_DATA / NB_BYTE;
  localparam int unsigned NB_IDX   = clog2_min1(BPW);
  localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(BPW - 1);

  logic [NB_DATA-1:0] r_word;
  logic [NB_IDX-1:0]  r_idx;
  logic               w_hs;
  logic               w_last;
  logic [NB_BYTE-1:0] w_byte;

  assign w_hs   = i_en & i_tx_ready;
  assign w_last = (r_idx == IDX_LAST);

  // Index saturates on the last byte; the next load rewinds it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_idx  <= '0;
    end else if (w_hs && !w_last) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  always_comb begin
    w_byte = '0;
    for (int unsigned i = 0; i < BPW; i++) begin
      if (r_idx == NB_IDX'(i)) w_byte = r_word[i*NB_BYTE +: NB_BYTE];
    end
  end

  assign o_tx_valid = i_en;
  assign o_tx_data  = i_en ? w_byte : '0;
  assign o_last_acc = w_hs & w_last;

endmodule

// File: rtl/register_file_dump_ctrl.sv
// Register-file dump sequencer: walks every register through the debug read port and streams
// the words out as bytes. Define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module register_file_dump_ctrl
  import register_file_dump_ctrl_pkg::*;
#(
  parameter int unsigned NB_DATA  = DEF_NB_DATA,
  parameter int unsigned N_REGS   = 32,
  parameter int unsigned NB_BYTE  = DEF_NB_BYTE,
  parameter int unsigned _NB_ADDR = $clog2(N_REGS)
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  register_file_dump_ctrl_if.slave io_bus
);

  localparam logic [_NB_ADDR-1:0] ADDR_LAST = _NB_ADDR'(N_REGS - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [_NB_ADDR-1:0] r_addr;
  logic [_NB_ADDR-1:0] w_addr_next;
  logic                w_load;
  logic                w_send;
  logic                w_last_acc;
  logic [NB_BYTE-1:0]  w_ser_data;
  logic                w_ser_valid;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]  r_csum;
  logic [NB_BYTE-1:0]  w_csum_next;
`endif

  assign w_load = (r_state == StLoad);
  assign w_send = (r_state == StSend);

  word_to_byte_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_word     (io_bus.i_data_debug),
    .i_en       (w_send),
    .i_tx_ready (io_bus.i_tx_ready),
    .o_tx_data  (w_ser_data),
    .o_tx_valid (w_ser_valid),
    .o_last_acc (w_last_acc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_addr  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum  <= w_csum_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
`ifdef REG_DUMP_CHECKSUM_EN
    w_csum_next  = r_csum;
`endif
    unique case (r_state)
      StIdle: begin
        if (io_bus.i_start) begin
          w_addr_next  = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          w_csum_next  = '0;
`endif
          w_state_next = StLoad;
        end
      end
      StLoad: w_state_next = StSend;
      StSend: begin
`ifdef REG_DUMP_CHECKSUM_EN
        if (io_bus.i_tx_ready) w_csum_next = r_csum ^ w_ser_data;
`endif
        // Terminal compare before increment so the address never wraps.
        if (w_last_acc) begin
          if (r_addr == ADDR_LAST) begin
`ifdef REG_DUMP_CHECKSUM_EN
            w_state_next = StCsum;
`else
            w_state_next = StDone;
`endif
          end else begin
            w_addr_next  = r_addr + 1'b1;
            w_state_next = StLoad;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      StCsum: begin
        if (io_bus.i_tx_ready) w_state_next = StDone;
      end
`endif
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign io_bus.o_busy            = (r_state == StLoad) || (r_state == StSend)
`ifdef REG_DUMP_CHECKSUM_EN
                                    || (r_state == StCsum)
`endif
                                    ;
  assign io_bus.o_done            = (r_state == StDone);
  assign io_bus.o_read_addr_debug = r_addr;

`ifdef REG_DUMP_CHECKSUM_EN
  assign io_bus.o_tx_valid = w_ser_valid | (r_state == StCsum);
  assign io_bus.o_tx_data  = (r_state == StCsum) ? r_csum : w_ser_data;
`else
  assign io_bus.o_tx_valid = w_ser_valid;
  assign io_bus.o_tx_data  = w_ser_data;
`endif

endmodule

// File: tb/tb_register_file_dump_ctrl.sv
// Self-checking bench for register_file_dump_ctrl: a behavioural register file plus a
// byte-stream reference model built directly from the register contents.
module tb_register_file_dump_ctrl;

  localparam int unsigned N   = 32;
  localparam int unsigned BPW = 4;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int unsigned CS = 1;
`else
  localparam int unsigned CS = 0;
`endif
  localparam int L = N * (BPW + 1) + CS;  // busy cycles per dump with ready held high

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] regs [N];
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          stab_err = 0;
  logic        prev_pend = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always #5 clk = ~clk;

  register_file_dump_ctrl_if bus ();
  assign bus.i_data_debug = regs[bus.o_read_addr_debug];

  register_file_dump_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  // Byte collector and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pend <= 1'b0;
    end else begin
      if (prev_pend && (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== prev_data))
        stab_err <= stab_err + 1;
      if (bus.o_tx_valid && bus.i_tx_ready) got.push_back(bus.o_tx_data);
      prev_pend <= bus.o_tx_valid && !bus.i_tx_ready;
      prev_data <= bus.o_tx_data;
    end
  end

  function automatic void build_exp();
    logic [7:0] x;
    logic [7:0] v;
    x = 8'h00;
    exp_q.delete();
    for (int r = 0; r < N; r++) begin
      for (int b = 0; b < BPW; b++) begin
        v = 8'((regs[r] >> (8 * b)) & 32'hFF);
        exp_q.push_back(v);
        x = x ^ v;
      end
    end
    if (CS != 0) exp_q.push_back(x);
  endfunction

  task automatic tick(input bit rdy_rand);
    @(posedge clk);
    #1;
    bus.i_tx_ready = rdy_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
  endtask

  task automatic run_dump(input bit rdy_rand, input bit pulse_mid,
                          output int done_cyc, output int busy_cyc, output int first_valid);
    got.delete();
    done_cyc    = -1;
    busy_cyc    = 0;
    first_valid = -1;
    bus.i_start = 1'b1;
    for (int n = 1; n <= 6000 && done_cyc < 0; n++) begin
      tick(rdy_rand);
      bus.i_start = pulse_mid && (n % 37 == 0);
      if (bus.o_busy) busy_cyc++;
      if (bus.o_tx_valid && first_valid < 0) first_valid = n;
      if (bus.o_done) done_cyc = n;
    end
    bus.i_start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) regs[i] = 32'(i);
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    n_checks++; if (bus.o_done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done: got %b want 0", bus.o_done); end
    n_checks++; if (bus.o_tx_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b want 0", bus.o_tx_valid); end
    n_checks++; if (bus.o_tx_data !== 8'h00) begin n_fail++;
      $display("FAIL reset_data: got %h want 00", bus.o_tx_data); end
    n_checks++; if (bus.o_read_addr_debug !== 5'd0) begin n_fail++;
      $display("FAIL reset_addr: got %0d want 0", bus.o_read_addr_debug); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick(0);
    n_checks++; if (bus.o_busy !== 1'b0 || bus.o_tx_valid !== 1'b0) begin n_fail++;
      $display("FAIL idle_no_start: busy %b valid %b want 0 0", bus.o_busy, bus.o_tx_valid); end
  endtask

  task automatic test_basic_dump();
    int dc, bc, fv;
    for (int i = 0; i < N; i++) regs[i] = 32'(i);
    build_exp();
    run_dump(1'b0, 1'b0, dc, bc, fv);
    n_checks++; if (dc != L + 1) begin n_fail++;
      $display("FAIL basic_done_cycle: got %0d want %0d", dc, L + 1); end
    n_checks++; if (bc != L) begin n_fail++;
      $display("FAIL basic_busy_cycles: got %0d want %0d", bc, L); end
    n_checks++; if (fv != 2) begin n_fail++;
      $display("FAIL basic_first_valid: got %0d want 2", fv); end
    n_checks++; if (got.size() != exp_q.size()) begin n_fail++;
      $display("FAIL basic_len: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL basic_byte[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
    n_checks++; if (bus.o_read_addr_debug !== 5'(N - 1)) begin n_fail++;
      $display("FAIL done_addr: got %0d want %0d", bus.o_read_addr_debug, N - 1); end
    tick(0);
    n_checks++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin n_fail++;
      $display("FAIL after_done: done %b busy %b want 0 0", bus.o_done, bus.o_busy); end
  endtask

  task automatic test_word_order();
    int dc, bc, fv;
    logic [7:0] want [4];
    want[0] = 8'hD4; want[1] = 8'hC3; want[2] = 8'hB2; want[3] = 8'hA1;
    for (int i = 0; i < N; i++) regs[i] = 32'(i);
    regs[5] = 32'hA1B2C3D4;
    run_dump(1'b0, 1'b0, dc, bc, fv);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got.size() <= 20 + i || got[20 + i] !== want[i]) begin n_fail++;
        $display("FAIL word5_byte%0d: got %h want %h", i,
                 (got.size() > 20 + i) ? got[20 + i] : 8'h00, want[i]); end
    end
    tick(0);
  endtask

  task automatic test_ready_throttle();
    int dc, bc, fv;
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    build_exp();
    stab_err = 0;
    run_dump(1'b1, 1'b1, dc, bc, fv);
    n_checks++; if (dc < 0) begin n_fail++;
      $display("FAIL throttle_done: no done within bound, got %0d want >0", dc); end
    n_checks++; if (bc != dc - 1) begin n_fail++;
      $display("FAIL throttle_busy: got %0d want %0d", bc, dc - 1); end
    n_checks++; if (stab_err != 0) begin n_fail++;
      $display("FAIL throttle_hold: got %0d violations want 0", stab_err); end
    n_checks++; if (got.size() != exp_q.size()) begin n_fail++;
      $display("FAIL throttle_len: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL throttle_byte[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
    tick(0);
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    logic b1 = 1'b1;
    logic b2 = 1'b0;
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    build_exp();
    got.delete();
    bus.i_start = 1'b1;
    for (int n = 1; n <= 2000 && d2 < 0; n++) begin
      tick(0);
      if (d1 > 0 && n == d1 + 1) b1 = bus.o_busy;
      if (d1 > 0 && n == d1 + 2) b2 = bus.o_busy;
      if (bus.o_done) begin
        if (d1 < 0) d1 = n;
        else d2 = n;
      end
    end
    bus.i_start = 1'b0;
    n_checks++; if (d1 != L + 1) begin n_fail++;
      $display("FAIL b2b_done1: got %0d want %0d", d1, L + 1); end
    n_checks++; if (d2 != 2 * L + 3) begin n_fail++;
      $display("FAIL b2b_done2: got %0d want %0d", d2, 2 * L + 3); end
    n_checks++; if (b1 !== 1'b0) begin n_fail++;
      $display("FAIL b2b_idle_gap: busy got %b want 0", b1); end
    n_checks++; if (b2 !== 1'b1) begin n_fail++;
      $display("FAIL b2b_restart: busy got %b want 1", b2); end
    n_checks++; if (got.size() != 2 * exp_q.size()) begin n_fail++;
      $display("FAIL b2b_len: got %0d want %0d", got.size(), 2 * exp_q.size()); end
    for (int i = 0; i < 2 * exp_q.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i % exp_q.size()]) begin n_fail++;
        $display("FAIL b2b_byte[%0d]: got %h want %h", i, got[i], exp_q[i % exp_q.size()]); end
    end
    tick(0);
  endtask

  task automatic test_mid_reset();
    int dc, bc, fv;
    int bad = 0;
    for (int i = 0; i < N; i++) regs[i] = 32'(i) ^ 32'h5A5A_0000;
    build_exp();
    got.delete();
    bus.i_start = 1'b1;
    for (int n = 1; n <= 53; n++) begin
      tick(0);
      bus.i_start = 1'b0;
    end
    n_checks++; if (bus.o_read_addr_debug !== 5'd10 || bus.o_tx_valid !== 1'b1) begin n_fail++;
      $display("FAIL midrst_pre: addr %0d valid %b want 10 1",
               bus.o_read_addr_debug, bus.o_tx_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin n_fail++;
      $display("FAIL midrst_ctrl: busy %b done %b want 0 0", bus.o_busy, bus.o_done); end
    n_checks++; if (bus.o_tx_valid !== 1'b0 || bus.o_tx_data !== 8'h00) begin n_fail++;
      $display("FAIL midrst_tx: valid %b data %h want 0 00", bus.o_tx_valid, bus.o_tx_data); end
    n_checks++; if (bus.o_read_addr_debug !== 5'd0) begin n_fail++;
      $display("FAIL midrst_addr: got %0d want 0", bus.o_read_addr_debug); end
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_done !== 1'b0) bad++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick(0);
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++;
      $display("FAIL midrst_no_done: got %0d bad cycles want 0", bad); end
    run_dump(1'b0, 1'b0, dc, bc, fv);
    n_checks++; if (dc != L + 1) begin n_fail++;
      $display("FAIL midrst_redo_done: got %0d want %0d", dc, L + 1); end
    n_checks++; if (got.size() != exp_q.size()) begin n_fail++;
      $display("FAIL midrst_redo_len: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL midrst_byte[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
    tick(0);
  endtask

  task automatic test_checksum();
    int dc, bc, fv;
    for (int i = 0; i < N; i++) regs[i] = 32'(i);
`ifdef REG_DUMP_CHECKSUM_EN
    run_dump(1'b0, 1'b0, dc, bc, fv);
    n_checks++; if (got.size() != 129 || got[128] !== 8'h00) begin n_fail++;
      $display("FAIL csum_reset_vals: len %0d last %h want 129 00", got.size(),
               (got.size() > 0) ? got[got.size() - 1] : 8'h00); end
    tick(0);
    regs[0] = 32'h0000_00FF;
    run_dump(1'b0, 1'b0, dc, bc, fv);
    n_checks++; if (got.size() != 129 || got[128] !== 8'hFF) begin n_fail++;
      $display("FAIL csum_reg0_ff: len %0d last %h want 129 ff", got.size(),
               (got.size() > 0) ? got[got.size() - 1] : 8'h00); end
`else
    regs[0] = 32'h0000_00FF;
    run_dump(1'b0, 1'b0, dc, bc, fv);
    n_checks++; if (got.size() != 128 || got[127] !== 8'h00) begin n_fail++;
      $display("FAIL no_csum_tail: len %0d last %h want 128 00", got.size(),
               (got.size() > 0) ? got[got.size() - 1] : 8'h00); end
`endif
    n_checks++; if (dc != L + 1) begin n_fail++;
      $display("FAIL csum_done_cycle: got %0d want %0d", dc, L + 1); end
    tick(0);
  endtask

  initial begin
    test_reset();
    test_basic_dump();
    test_word_order();
    test_ready_throttle();
    test_back_to_back();
    test_mid_reset();
    test_checksum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
